stopwatch_counter: RTL
======================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter: INIT_PAUSED, default 0, run state entered on reset (0 = RUN, 1 = PAUSED).
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: tick_1hz  in  1  single-cycle count-enable pulse, clk domain.
REQ-005 SHALL have port: tick_2hz  in  1  single-cycle adjust-rate pulse, clk domain.
REQ-006 SHALL have port: pause_pulse  in  1  single-cycle toggle request, already debounced and synchronised.
REQ-007 SHALL have port: adj  in  1  level, 1 = adjust mode.
REQ-008 SHALL have port: sel  in  1  level, adjust target (0 = minutes, 1 = seconds).
REQ-009 SHALL have ports: min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits, registered.
REQ-010 SHALL have port: running  out  1  1 when state = RUN, registered.
REQ-011 SHALL have port: wrap  out  1  single-cycle pulse on 59:59 -> 00:00 rollover, registered.

Function
REQ-012 SHALL implement a two-state FSM, RUN and PAUSED; pause_pulse=1 toggles the state at the sampling edge.
REQ-013 SHALL, with adj=0 and state=RUN, increment seconds on each edge sampling tick_1hz=1; results visible the following cycle (one-cycle latency).
REQ-014 SHALL count seconds 00..59 in BCD: sec_ones 9->0 with a carry into sec_tens; sec_tens 5->0 with a carry into minutes.
REQ-015 SHALL count minutes 00..59 in BCD using the same rule; 59:59 + 1 -> 00:00, with wrap=1 for exactly that one cycle.
REQ-016 SHALL ignore tick_1hz whenever state=PAUSED or adj=1.
REQ-017 SHALL, with adj=1, increment only the sel-selected field by 1 modulo 60 on each tick_2hz=1, in both RUN and PAUSED.
REQ-018 SHALL NOT carry into the other field during adjust, and SHALL hold wrap=0.
REQ-019 SHALL ignore tick_2hz when adj=0.
REQ-020 SHALL leave the FSM state unchanged by adj; the count resumes per the state once adj returns to 0.
REQ-021 SHALL evaluate the increment against the pre-toggle state when pause_pulse coincides with tick_1hz: in RUN the tick counts and the state then becomes PAUSED; in PAUSED the tick is dropped and the state becomes RUN.
REQ-022 SHALL sample adj and sel each cycle, with no latching; a change takes effect on the same edge it is sampled.
REQ-023 SHALL only ever present valid BCD on all digit outputs, i.e. tens <= 5 and ones <= 9.
REQ-024 SHALL apply at most one increment per cycle; simultaneous tick_1hz and tick_2hz are resolved by adj alone.

Reset
REQ-025 SHALL, on rst=1 and without waiting for clk, clear all digits to 0, set wrap=0, and set the state to RUN (INIT_PAUSED=0) or PAUSED (INIT_PAUSED=1).
REQ-026 SHALL drive running to match the reset state while rst is held, and SHALL ignore all other inputs while rst=1.
REQ-027 SHALL resume operation on the first clk edge after rst deasserts; a pulse on that edge is honoured.

Verification
REQ-028 SHALL cover: reset, adj=0, 60 tick_1hz pulses -> 01:00, wrap never asserted.
REQ-029 SHALL cover: adj=1 sel=0 with 59 tick_2hz, then sel=1 with 59 tick_2hz -> 59:59; then adj=0 and one tick_1hz -> 00:00 with wrap=1 for exactly one cycle.
REQ-030 SHALL cover: pause_pulse, then 5 tick_1hz -> digits unchanged and running=0; pause_pulse, then 3 tick_1hz -> +3 s and running=1.
REQ-031 SHALL cover: at 00:09 in RUN, pause_pulse and tick_1hz on the same edge -> 00:10 and running=0; repeat while PAUSED -> 00:10 held and running=1.
REQ-032 SHALL cover: at 07:58 with adj=1 sel=1, 3 tick_2hz interleaved with tick_1hz pulses -> 07:01, minutes held, wrap=0.
REQ-033 SHALL cover: at 12:34, rst asserted between clk edges -> 00:00 and running=1 before the next edge; the first tick_1hz after release -> 00:01.

Source files
------------

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//
// MM:SS stopwatch. It counts seconds and minutes in BCD from 00:00 to 59:59
// and rolls over. A two-state run/pause FSM gates the 1 Hz count. An adjust
// mode lets the user step the minutes or the seconds field at the 2 Hz rate.
//
// Parameters
//   INIT_PAUSED : state entered on reset (0 = RUN, 1 = PAUSED)
//
// Ports
//   clk         : system clock, all state updates on the rising edge
//   rst         : asynchronous active-high reset
//   tick_1hz    : single-cycle count-enable pulse
//   tick_2hz    : single-cycle adjust-rate pulse
//   pause_pulse : single-cycle run/pause toggle request
//   adj         : level, 1 = adjust mode
//   sel         : level, adjust target (0 = minutes, 1 = seconds)
//   min_tens, min_ones, sec_tens, sec_ones : registered BCD digits
//   running     : registered, 1 while the FSM is in RUN
//   wrap        : registered single-cycle pulse on the 59:59 -> 00:00 rollover
// ---------------------------------------------------------------------------
module stopwatch_counter #(
  parameter bit INIT_PAUSED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_PAUSED ? PAUSED : RUN;

  state_t     state;
  state_t     state_next;
  logic [3:0] min_tens_next;
  logic [3:0] min_ones_next;
  logic [3:0] sec_tens_next;
  logic [3:0] sec_ones_next;
  logic       wrap_next;

  // Add one to a two-digit BCD field modulo 60. The result is {tens, ones}.
  function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = tens;
    o = ones;
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd5) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Next-state and next-count logic.
  // The increment is decided from the current (pre-toggle) state. A
  // pause_pulse arriving on the same edge as tick_1hz therefore does not
  // change whether that tick counts.
  // adj alone chooses which tick source is active, so at most one increment
  // happens per cycle.
  always_comb begin
    state_next    = state;
    min_tens_next = min_tens;
    min_ones_next = min_ones;
    sec_tens_next = sec_tens;
    sec_ones_next = sec_ones;
    wrap_next     = 1'b0;

    if (pause_pulse) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end

    if (adj) begin
      // Adjust mode changes only the selected field and never carries.
      if (tick_2hz) begin
        if (sel) begin
          {sec_tens_next, sec_ones_next} = inc60(sec_tens, sec_ones);
        end else begin
          {min_tens_next, min_ones_next} = inc60(min_tens, min_ones);
        end
      end
    end else if (tick_1hz && (state == RUN)) begin
      {sec_tens_next, sec_ones_next} = inc60(sec_tens, sec_ones);
      if ((sec_tens == 4'd5) && (sec_ones == 4'd9)) begin
        {min_tens_next, min_ones_next} = inc60(min_tens, min_ones);
        wrap_next = (min_tens == 4'd5) && (min_ones == 4'd9);
      end
    end
  end

  // State, digit and flag registers.
  // running is registered from the next state, so it stays cycle-aligned
  // with the state register and also tracks the reset state while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      running  <= (RESET_STATE == RUN);
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_next;
      running  <= (state_next == RUN);
      min_tens <= min_tens_next;
      min_ones <= min_ones_next;
      sec_tens <= sec_tens_next;
      sec_ones <= sec_ones_next;
      wrap     <= wrap_next;
    end
  end

endmodule
